miss_sequencer: RTL and testbench

Per-cache controller that sequences a line miss against main memory: optional dirty-victim write-back, then block fetch, then a one-cycle fill pulse to the cache array. It sits between cache lookup/replacement logic and the memory side of the controller interface (fetch/write-back address, data, ack). One miss is in flight at a time; new misses are back-pressured.

---
 rtl/miss_sequencer.sv | 142 ++++++++++++++
 tb/tb_miss_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/miss_sequencer.sv
// Line-miss sequencer: optional dirty-victim write-back, block fetch, then a one-cycle fill.
// Build option MISS_TIMEOUT_EN adds a COUNTER_WIDTH ack timeout that aborts the miss and pulses missError.
module miss_sequencer #(
  parameter int NUM_WAYS      = 4,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         missValid,
  output logic                         missReady,
  input  logic [ADDRESS_WIDTH-1:0]     missAddress,
  input  logic [$clog2(NUM_WAYS)-1:0]  victimWay,
  input  logic                         victimDirty,
  input  logic [ADDRESS_WIDTH-1:0]     victimAddress,
  input  logic [8*BLOCK_SIZE-1:0]      victimData,
  output logic                         writeBackReq,
  output logic [ADDRESS_WIDTH-1:0]     writeBackAddress,
  output logic [8*BLOCK_SIZE-1:0]      writeBackData,
  input  logic                         writeBackAck,
  output logic                         fetchReq,
  output logic [ADDRESS_WIDTH-1:0]     fetchAddress,
  input  logic                         fetchAck,
  input  logic [8*BLOCK_SIZE-1:0]      fetchedData,
  output logic                         fillValid,
  output logic [$clog2(NUM_WAYS)-1:0]  fillWay,
  output logic [ADDRESS_WIDTH-1:0]     fillAddress,
  output logic [8*BLOCK_SIZE-1:0]      fillData,
  output logic                         missError,
  output logic [1:0]                   stateDebug
);

  localparam int WAY_BITS = $clog2(NUM_WAYS);
  localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK = ADDRESS_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    FILL      = 2'd3
  } seqState_e;

  seqState_e           state;
  logic [WAY_BITS-1:0] pendingWay;

  // Handshake: a miss is accepted on a rising edge where missValid && missReady;
  // each memory request stays high until its ack is seen on a rising edge while the
  // request is high in the matching state. Acks at any other time are ignored.
  assign missReady  = (state == IDLE);
  assign stateDebug = state;

`ifdef MISS_TIMEOUT_EN
  // Abort on the edge where the counter would reach all-ones.
  localparam logic [COUNTER_WIDTH-1:0] LAST_WAIT = ~COUNTER_WIDTH'(1);
  logic [COUNTER_WIDTH-1:0] waitCount;
`else
  assign missError = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pendingWay       <= '0;
      writeBackReq     <= 1'b0;
      writeBackAddress <= '0;
      writeBackData    <= '0;
      fetchReq         <= 1'b0;
      fetchAddress     <= '0;
      fillValid        <= 1'b0;
      fillWay          <= '0;
      fillAddress      <= '0;
      fillData         <= '0;
`ifdef MISS_TIMEOUT_EN
      waitCount        <= '0;
      missError        <= 1'b0;
`endif
    end else begin
      fillValid <= 1'b0;
`ifdef MISS_TIMEOUT_EN
      missError <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (missValid) begin
            fetchAddress     <= missAddress & ~OFFSET_MASK;
            writeBackAddress <= victimAddress & ~OFFSET_MASK;
            writeBackData    <= victimData;
            pendingWay       <= victimWay;
`ifdef MISS_TIMEOUT_EN
            waitCount        <= '0;
`endif
            if (victimDirty) begin
              writeBackReq <= 1'b1;
              state        <= WRITEBACK;
            end else begin
              fetchReq <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        WRITEBACK: begin
          if (writeBackReq && writeBackAck) begin
            writeBackReq <= 1'b0;
            fetchReq     <= 1'b1;
            state        <= FETCH;
`ifdef MISS_TIMEOUT_EN
            waitCount    <= '0;
          end else if (waitCount == LAST_WAIT) begin
            writeBackReq <= 1'b0;
            missError    <= 1'b1;
            state        <= IDLE;
          end else begin
            waitCount <= waitCount + 1'b1;
`endif
          end
        end
        FETCH: begin
          if (fetchReq && fetchAck) begin
            fetchReq    <= 1'b0;
            fillData    <= fetchedData;
            fillWay     <= pendingWay;
            fillAddress <= fetchAddress;
            fillValid   <= 1'b1;
            state       <= FILL;
`ifdef MISS_TIMEOUT_EN
          end else if (waitCount == LAST_WAIT) begin
            fetchReq  <= 1'b0;
            missError <= 1'b1;
            state     <= IDLE;
          end else begin
            waitCount <= waitCount + 1'b1;
`endif
          end
        end
        FILL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miss_sequencer.sv
// Directed bench for miss_sequencer: clean, dirty, back-pressure, stray-ack and reset cases,
// plus the timeout abort when built with MISS_TIMEOUT_EN.
module tb_miss_sequencer;

  localparam int DW = 256;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           missValid = 1'b0;
  logic           missReady;
  logic [31:0]    missAddress = '0;
  logic [1:0]     victimWay = '0;
  logic           victimDirty = 1'b0;
  logic [31:0]    victimAddress = '0;
  logic [DW-1:0]  victimData = '0;
  logic           writeBackReq;
  logic [31:0]    writeBackAddress;
  logic [DW-1:0]  writeBackData;
  logic           writeBackAck = 1'b0;
  logic           fetchReq;
  logic [31:0]    fetchAddress;
  logic           fetchAck = 1'b0;
  logic [DW-1:0]  fetchedData = '0;
  logic           fillValid;
  logic [1:0]     fillWay;
  logic [31:0]    fillAddress;
  logic [DW-1:0]  fillData;
  logic           missError;
  logic [1:0]     stateDebug;

  int testCount = 0;
  int failCount = 0;
  int fillCount = 0;
  int overlapCount = 0;
  logic [DW-1:0] expQ[$];

  miss_sequencer #(.NUM_WAYS(4), .BLOCK_SIZE(32), .ADDRESS_WIDTH(32), .COUNTER_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .missValid(missValid), .missReady(missReady), .missAddress(missAddress),
    .victimWay(victimWay), .victimDirty(victimDirty), .victimAddress(victimAddress),
    .victimData(victimData),
    .writeBackReq(writeBackReq), .writeBackAddress(writeBackAddress),
    .writeBackData(writeBackData), .writeBackAck(writeBackAck),
    .fetchReq(fetchReq), .fetchAddress(fetchAddress), .fetchAck(fetchAck),
    .fetchedData(fetchedData),
    .fillValid(fillValid), .fillWay(fillWay), .fillAddress(fillAddress), .fillData(fillData),
    .missError(missError), .stateDebug(stateDebug)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [DW-1:0] actual,
                            input logic [DW-1:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveMiss(input logic [31:0] addr, input logic [1:0] way, input logic dirty,
                           input logic [31:0] vAddr, input logic [DW-1:0] vData);
    missValid     = 1'b1;
    missAddress   = addr;
    victimWay     = way;
    victimDirty   = dirty;
    victimAddress = vAddr;
    victimData    = vData;
  endtask

  // Scoreboard: every fill pulse must match the next expected block; reqs must never overlap.
  always @(negedge clk) begin
    if (writeBackReq && fetchReq) overlapCount++;
    if (fillValid) begin
      fillCount++;
      if (expQ.size() == 0) checkValue("unexpected fill", 1, 0);
      else checkValue("scoreboard fillData", fillData, expQ.pop_front());
    end
  end

  initial begin
    logic [DW-1:0] patA5, patBeef, patC3, pat11, pat22, pat77;
    patA5   = {32{8'hA5}};
    patBeef = {8{32'hDEADBEEF}};
    patC3   = {32{8'hC3}};
    pat11   = {32{8'h11}};
    pat22   = {32{8'h22}};
    pat77   = {32{8'h77}};

    // Reset
    #12 rst_n = 1'b1;
    tick();
    checkValue("reset missReady", missReady, 1);
    checkValue("reset fetchReq", fetchReq, 0);
    checkValue("reset writeBackReq", writeBackReq, 0);
    checkValue("reset fillValid", fillValid, 0);
    checkValue("reset missError", missError, 0);
    checkValue("reset fillData", fillData, 0);

    // Clean miss, ack three cycles after fetchReq
    expQ.push_back(patA5);
    driveMiss(32'h0000_1234, 2'd2, 1'b0, 32'h0000_9000, patBeef);
    tick();
    missValid = 1'b0;
    checkValue("clean fetchReq", fetchReq, 1);
    checkValue("clean no writeBackReq", writeBackReq, 0);
    checkValue("clean missReady low", missReady, 0);
    checkValue("clean fetchAddress", fetchAddress, 32'h0000_1220);
    tick();
    tick();
    checkValue("clean fetchReq held", fetchReq, 1);
    fetchAck = 1'b1;
    fetchedData = patA5;
    tick();
    fetchAck = 1'b0;
    checkValue("clean fillValid", fillValid, 1);
    checkValue("clean fetchReq dropped", fetchReq, 0);
    checkValue("clean fillWay", fillWay, 2);
    checkValue("clean fillAddress", fillAddress, 32'h0000_1220);
    checkValue("clean fillData", fillData, patA5);
    tick();
    checkValue("clean fillValid one cycle", fillValid, 0);
    checkValue("clean missReady back", missReady, 1);
    checkValue("clean fillData held", fillData, patA5);

    // Dirty miss: write-back then fetch
    expQ.push_back(patC3);
    driveMiss(32'h0000_2000, 2'd1, 1'b1, 32'h0000_8040, patBeef);
    tick();
    missValid = 1'b0;
    victimAddress = 32'h0000_FFFF;
    victimData = pat77;
    checkValue("dirty writeBackReq", writeBackReq, 1);
    checkValue("dirty no fetchReq yet", fetchReq, 0);
    checkValue("dirty writeBackAddress", writeBackAddress, 32'h0000_8040);
    tick();
    checkValue("dirty writeBackData stable", writeBackData, patBeef);
    checkValue("dirty writeBackAddress stable", writeBackAddress, 32'h0000_8040);
    writeBackAck = 1'b1;
    tick();
    writeBackAck = 1'b0;
    checkValue("dirty writeBackReq dropped", writeBackReq, 0);
    checkValue("dirty fetchReq follows", fetchReq, 1);
    checkValue("dirty fetchAddress", fetchAddress, 32'h0000_2000);
    fetchAck = 1'b1;
    fetchedData = patC3;
    tick();
    fetchAck = 1'b0;
    checkValue("dirty fillValid", fillValid, 1);
    checkValue("dirty fillWay", fillWay, 1);
    checkValue("dirty fillAddress", fillAddress, 32'h0000_2000);
    tick();
    checkValue("dirty missReady back", missReady, 1);

    // Back-pressure: missValid held through an active miss, minimum-latency acks
    expQ.push_back(pat11);
    expQ.push_back(pat22);
    driveMiss(32'h0000_3000, 2'd0, 1'b0, 32'h0, '0);
    tick();
    missAddress = 32'h0000_4444;
    victimWay = 2'd3;
    checkValue("bp missReady low", missReady, 0);
    fetchAck = 1'b1;
    fetchedData = pat11;
    tick();
    fetchAck = 1'b0;
    checkValue("bp first fillValid", fillValid, 1);
    checkValue("bp first fillAddress", fillAddress, 32'h0000_3000);
    checkValue("bp missReady low at fill", missReady, 0);
    tick();
    checkValue("bp missReady after fill", missReady, 1);
    checkValue("bp no fetch before accept", fetchReq, 0);
    tick();
    missValid = 1'b0;
    checkValue("bp second fetchReq", fetchReq, 1);
    checkValue("bp second fetchAddress", fetchAddress, 32'h0000_4440);
    fetchAck = 1'b1;
    fetchedData = pat22;
    tick();
    fetchAck = 1'b0;
    checkValue("bp second fillWay", fillWay, 3);
    checkValue("bp second fillAddress", fillAddress, 32'h0000_4440);
    tick();

    // Stray acks
    fetchAck = 1'b1;
    writeBackAck = 1'b1;
    fetchedData = pat77;
    tick();
    fetchAck = 1'b0;
    writeBackAck = 1'b0;
    checkValue("stray idle missReady", missReady, 1);
    checkValue("stray idle fillValid", fillValid, 0);
    checkValue("stray idle fetchReq", fetchReq, 0);
    expQ.push_back(pat11);
    driveMiss(32'h0000_5000, 2'd1, 1'b0, 32'h0, '0);
    tick();
    missValid = 1'b0;
    writeBackAck = 1'b1;
    tick();
    writeBackAck = 1'b0;
    checkValue("stray wb fetchReq held", fetchReq, 1);
    checkValue("stray wb no writeBackReq", writeBackReq, 0);
    checkValue("stray wb no fill", fillValid, 0);
    fetchAck = 1'b1;
    fetchedData = pat11;
    tick();
    fetchAck = 1'b0;
    checkValue("stray recover fillValid", fillValid, 1);
    tick();

    // Reset mid-fetch
    driveMiss(32'h0000_6000, 2'd2, 1'b0, 32'h0, '0);
    tick();
    missValid = 1'b0;
    checkValue("rst fetchReq before", fetchReq, 1);
    #2 rst_n = 1'b0;
    #1;
    checkValue("rst fetchReq async", fetchReq, 0);
    checkValue("rst fillValid async", fillValid, 0);
    fetchAck = 1'b1;
    fetchedData = pat77;
    @(negedge clk);
    rst_n = 1'b1;
    fetchAck = 1'b0;
    tick();
    checkValue("rst missReady", missReady, 1);
    checkValue("rst fetchReq after", fetchReq, 0);
    checkValue("rst fillValid after", fillValid, 0);
    checkValue("rst fillData cleared", fillData, 0);
    tick();

`ifdef MISS_TIMEOUT_EN
    // Timeout: fetchAck never arrives
    begin
      int waitCycles;
      waitCycles = 0;
      driveMiss(32'h0000_7000, 2'd0, 1'b0, 32'h0, '0);
      tick();
      missValid = 1'b0;
      while (fetchReq && waitCycles < 40) begin
        waitCycles++;
        tick();
      end
      checkValue("timeout wait cycles", waitCycles, 15);
      checkValue("timeout missError", missError, 1);
      checkValue("timeout no fill", fillValid, 0);
      checkValue("timeout missReady", missReady, 1);
      tick();
      checkValue("timeout missError pulse", missError, 0);
    end
`else
    checkValue("missError tied low", missError, 0);
`endif

    tick();
    checkValue("total fills", fillCount, 5);
    checkValue("scoreboard drained", expQ.size(), 0);
    checkValue("req overlap", overlapCount, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
